// File: rtl/apb_bridge_controller.sv
`default_nettype none
// ============================================================================
// Module      : apb_bridge_controller
// Description : APB-side sequencing FSM of the AHB2APB bridge. Generates APB
//               setup/enable phases and Hreadyout from the slave interface's
//               decoded transfer and pipelined address/data registers.
//               Optional macro APB_PREADY_WAIT_EN adds Pready wait states.
// Revision    : 1.0 - initial release
// ============================================================================
module apb_bridge_controller #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int NSEL   = 3
) (
    input  logic              Hclk,
    input  logic              Hreset,
    input  logic              valid,
    input  logic              Hwrite,
    input  logic              Hwritereg,
    input  logic [ADDR_W-1:0] Haddr,
    input  logic [ADDR_W-1:0] Haddr1,
    input  logic [ADDR_W-1:0] Haddr2,
    input  logic [DATA_W-1:0] Hwdata,
    input  logic [DATA_W-1:0] Hwdata1,
    input  logic [NSEL-1:0]   tempselx,
    input  logic              Pready,
    output logic              Hreadyout,
    output logic              Pwrite,
    output logic              Penable,
    output logic [NSEL-1:0]   Pselx,
    output logic [ADDR_W-1:0] Paddr,
    output logic [DATA_W-1:0] Pwdata
);

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_WWAIT    = 3'd1,
        ST_READ     = 3'd2,
        ST_WRITE    = 3'd3,
        ST_WRITEP   = 3'd4,
        ST_RENABLE  = 3'd5,
        ST_WENABLE  = 3'd6,
        ST_WENABLEP = 3'd7
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [NSEL-1:0]   r_sel_d1;
    logic [NSEL-1:0]   r_sel_d2;

    logic              r_hreadyout, w_hreadyout;
    logic              r_pwrite,    w_pwrite;
    logic              r_penable,   w_penable;
    logic [NSEL-1:0]   r_pselx,     w_pselx;
    logic [ADDR_W-1:0] r_paddr,     w_paddr;
    logic [DATA_W-1:0] r_pwdata,    w_pwdata;
    logic              w_stall;

`ifdef APB_PREADY_WAIT_EN
    // Enable phases present Hreadyout low until the peripheral completes
    localparam logic c_en_hready = 1'b0;

    assign w_stall = !Pready && ((r_state == ST_RENABLE) ||
                                 (r_state == ST_WENABLE) ||
                                 (r_state == ST_WENABLEP));
`else
    localparam logic c_en_hready = 1'b1;

    logic w_unused_pready;
    assign w_unused_pready = Pready;
    assign w_stall         = 1'b0;
`endif

    always_comb begin
        w_state_nxt = r_state;
        w_hreadyout = r_hreadyout;
        w_pwrite    = r_pwrite;
        w_penable   = r_penable;
        w_pselx     = r_pselx;
        w_paddr     = r_paddr;
        w_pwdata    = r_pwdata;

        case (r_state)
            ST_IDLE, ST_WENABLE, ST_RENABLE: begin
                if (!valid)
                    w_state_nxt = ST_IDLE;
                else if (Hwrite)
                    w_state_nxt = ST_WWAIT;
                else
                    w_state_nxt = ST_READ;
            end
            ST_WWAIT:  w_state_nxt = valid ? ST_WRITEP : ST_WRITE;
            ST_WRITE:  w_state_nxt = valid ? ST_WENABLEP : ST_WENABLE;
            ST_WRITEP: w_state_nxt = ST_WENABLEP;
            ST_WENABLEP: begin
                if (!Hwritereg)
                    w_state_nxt = ST_READ;
                else if (valid)
                    w_state_nxt = ST_WRITEP;
                else
                    w_state_nxt = ST_WRITE;
            end
            ST_READ:   w_state_nxt = ST_RENABLE;
            default:   w_state_nxt = ST_IDLE;
        endcase

        if (w_stall) begin
            w_state_nxt = r_state;
            w_hreadyout = 1'b0;
        end else begin
            // Outputs take the entry values of the state being entered
            case (w_state_nxt)
                ST_IDLE, ST_WWAIT: begin
                    w_pselx     = '0;
                    w_penable   = 1'b0;
                    w_hreadyout = 1'b1;
                end
                ST_READ: begin
                    w_paddr     = Haddr;
                    w_pselx     = tempselx;
                    w_pwrite    = 1'b0;
                    w_penable   = 1'b0;
                    w_hreadyout = 1'b0;
                end
                ST_WRITE, ST_WRITEP: begin
                    // After a pipelined enable the pending write sits one stage deeper
                    if (r_state == ST_WENABLEP) begin
                        w_paddr  = Haddr2;
                        w_pselx  = r_sel_d2;
                        w_pwdata = Hwdata1;
                    end else begin
                        w_paddr  = Haddr1;
                        w_pselx  = r_sel_d1;
                        w_pwdata = Hwdata;
                    end
                    w_pwrite    = 1'b1;
                    w_penable   = 1'b0;
                    w_hreadyout = (w_state_nxt == ST_WRITE);
                end
                default: begin
                    w_penable   = 1'b1;
                    w_hreadyout = c_en_hready;
                end
            endcase
        end
    end

    always_ff @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            r_state     <= ST_IDLE;
            r_sel_d1    <= '0;
            r_sel_d2    <= '0;
            r_hreadyout <= 1'b1;
            r_pwrite    <= 1'b0;
            r_penable   <= 1'b0;
            r_pselx     <= '0;
            r_paddr     <= '0;
            r_pwdata    <= '0;
        end else begin
            r_state     <= w_state_nxt;
            r_sel_d1    <= tempselx;
            r_sel_d2    <= r_sel_d1;
            r_hreadyout <= w_hreadyout;
            r_pwrite    <= w_pwrite;
            r_penable   <= w_penable;
            r_pselx     <= w_pselx;
            r_paddr     <= w_paddr;
            r_pwdata    <= w_pwdata;
        end
    end

    assign Hreadyout = r_hreadyout;
    assign Pwrite    = r_pwrite;
    assign Penable   = r_penable;
    assign Pselx     = r_pselx;
    assign Paddr     = r_paddr;
    assign Pwdata    = r_pwdata;

endmodule
`default_nettype wire

// File: tb/tb_apb_bridge_controller.sv
`default_nettype none
// ============================================================================
// Module      : tb_apb_bridge_controller
// Description : Scoreboard bench for apb_bridge_controller; APB phases are
//               queued at stimulus time and popped by a negedge monitor.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_apb_bridge_controller;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int NSEL   = 3;

`ifdef APB_PREADY_WAIT_EN
    localparam logic c_wait_en = 1'b1;
`else
    localparam logic c_wait_en = 1'b0;
`endif
    localparam logic c_en_hr = !c_wait_en;

    logic              Hclk = 1'b0;
    logic              Hreset = 1'b1;
    logic              valid = 1'b0;
    logic              Hwrite = 1'b0;
    logic              Hwritereg;
    logic [ADDR_W-1:0] Haddr = '0;
    logic [ADDR_W-1:0] Haddr1, Haddr2;
    logic [DATA_W-1:0] Hwdata = '0;
    logic [DATA_W-1:0] Hwdata1;
    logic [NSEL-1:0]   tempselx = '0;
    logic              Pready = 1'b1;
    logic              Hreadyout, Pwrite, Penable;
    logic [NSEL-1:0]   Pselx;
    logic [ADDR_W-1:0] Paddr;
    logic [DATA_W-1:0] Pwdata;

    apb_bridge_controller #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .NSEL(NSEL)) dut (
        .Hclk(Hclk), .Hreset(Hreset), .valid(valid), .Hwrite(Hwrite),
        .Hwritereg(Hwritereg), .Haddr(Haddr), .Haddr1(Haddr1), .Haddr2(Haddr2),
        .Hwdata(Hwdata), .Hwdata1(Hwdata1), .tempselx(tempselx), .Pready(Pready),
        .Hreadyout(Hreadyout), .Pwrite(Pwrite), .Penable(Penable), .Pselx(Pselx),
        .Paddr(Paddr), .Pwdata(Pwdata)
    );

    always #5 Hclk = ~Hclk;

    // Model of the AHB slave interface's pipeline registers
    always @(posedge Hclk or posedge Hreset) begin
        if (Hreset) begin
            Haddr1 <= '0; Haddr2 <= '0; Hwdata1 <= '0; Hwritereg <= 1'b0;
        end else begin
            Haddr1 <= Haddr; Haddr2 <= Haddr1; Hwdata1 <= Hwdata; Hwritereg <= Hwrite;
        end
    end

    typedef struct packed {
        logic              penable;
        logic              hready;
        logic              pwrite;
        logic [NSEL-1:0]   sel;
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    function automatic exp_t mk(input logic pen, input logic hr, input logic pw,
                                input logic [NSEL-1:0] s, input logic [ADDR_W-1:0] a,
                                input logic [DATA_W-1:0] d);
        exp_t e;
        e.penable = pen; e.hready = hr; e.pwrite = pw; e.sel = s; e.addr = a; e.data = d;
        return e;
    endfunction

    task automatic push_read(input logic [ADDR_W-1:0] a, input logic [NSEL-1:0] s);
        q.push_back(mk(1'b0, 1'b0, 1'b0, s, a, '0));
        q.push_back(mk(1'b1, c_en_hr, 1'b0, s, a, '0));
    endtask

    task automatic push_write(input logic [ADDR_W-1:0] a, input logic [NSEL-1:0] s,
                              input logic [DATA_W-1:0] d, input logic hr_setup);
        q.push_back(mk(1'b0, hr_setup, 1'b1, s, a, d));
        q.push_back(mk(1'b1, c_en_hr, 1'b1, s, a, d));
    endtask

    task automatic drive(input logic v, input logic w, input logic [ADDR_W-1:0] a,
                         input logic [NSEL-1:0] s, input logic [DATA_W-1:0] d);
        valid = v; Hwrite = w; Haddr = a; tempselx = s; Hwdata = d;
        @(posedge Hclk); #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, need %h", name, act, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_hreadyout"}, 64'(Hreadyout), 64'd1);
        chk({tag, "_pselx"},     64'(Pselx),     64'd0);
        chk({tag, "_penable"},   64'(Penable),   64'd0);
        chk({tag, "_pwrite"},    64'(Pwrite),    64'd0);
        chk({tag, "_paddr"},     64'(Paddr),     64'd0);
        chk({tag, "_pwdata"},    64'(Pwdata),    64'd0);
    endtask

    // Monitor: every selected cycle is an APB phase to be matched in order
    always @(negedge Hclk) begin
        exp_t e;
        if (!Hreset) begin
            n_vec++;
            if (Pselx != '0) begin
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL apb_unexpected: got sel=%b addr=%h pen=%b, need no phase",
                             Pselx, Paddr, Penable);
                end else begin
                    e = q.pop_front();
                    if (Penable !== e.penable || Hreadyout !== e.hready || Pwrite !== e.pwrite ||
                        Pselx !== e.sel || Paddr !== e.addr || (e.pwrite && Pwdata !== e.data)) begin
                        n_err++;
                        $display("FAIL apb_phase: got pen=%b hr=%b pw=%b sel=%b addr=%h data=%h, need pen=%b hr=%b pw=%b sel=%b addr=%h data=%h",
                                 Penable, Hreadyout, Pwrite, Pselx, Paddr, Pwdata,
                                 e.penable, e.hready, e.pwrite, e.sel, e.addr, e.data);
                    end
                end
            end else if (Hreadyout !== 1'b1 || Penable !== 1'b0) begin
                n_err++;
                $display("FAIL idle_cycle: got hr=%b pen=%b, need hr=1 pen=0", Hreadyout, Penable);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, need $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(posedge Hclk);
        #1;
        chk_reset_outputs("por");
        Hreset = 1'b0;

        // Single read
        push_read(32'h8000_0004, 3'b001);
        drive(1'b1, 1'b0, 32'h8000_0004, 3'b001, '0);
        drive(1'b0, 1'b0, 32'h8000_0004, 3'b000, '0);
        drive(1'b0, 1'b0, 32'h8000_0004, 3'b000, '0);
        drive(1'b0, 1'b0, 32'h8000_0004, 3'b000, '0);

        // Single write
        push_write(32'h8400_0010, 3'b010, 32'hDEAD_BEEF, 1'b1);
        drive(1'b1, 1'b1, 32'h8400_0010, 3'b010, '0);
        drive(1'b0, 1'b1, 32'h8400_0010, 3'b000, 32'hDEAD_BEEF);
        repeat (3) drive(1'b0, 1'b1, 32'h8400_0010, 3'b000, '0);

        // Back-to-back writes: WWAIT, WRITEP, WENABLEP, WRITE, WENABLE
        push_write(32'h8800_0000, 3'b100, 32'h1111_1111, 1'b0);
        push_write(32'h8800_0004, 3'b100, 32'h2222_2222, 1'b1);
        drive(1'b1, 1'b1, 32'h8800_0000, 3'b100, '0);
        drive(1'b1, 1'b1, 32'h8800_0004, 3'b100, 32'h1111_1111);
        drive(1'b0, 1'b1, 32'h8800_0004, 3'b000, 32'h2222_2222);
        repeat (4) drive(1'b0, 1'b1, 32'h8800_0004, 3'b000, '0);

        // Write then read through WENABLEP -> READ
        push_write(32'h8000_0008, 3'b001, 32'hCAFE_F00D, 1'b0);
        push_read(32'h8400_0000, 3'b010);
        drive(1'b1, 1'b1, 32'h8000_0008, 3'b001, '0);
        drive(1'b1, 1'b0, 32'h8400_0000, 3'b010, 32'hCAFE_F00D);
        drive(1'b1, 1'b0, 32'h8400_0000, 3'b010, '0);
        drive(1'b1, 1'b0, 32'h8400_0000, 3'b010, '0);
        repeat (4) drive(1'b0, 1'b0, 32'h8400_0000, 3'b000, '0);

        // Read issued during RENABLE starts the next read directly
        push_read(32'h8000_0020, 3'b001);
        push_read(32'h8400_000C, 3'b010);
        drive(1'b1, 1'b0, 32'h8000_0020, 3'b001, '0);
        drive(1'b0, 1'b0, 32'h8000_0020, 3'b000, '0);
        drive(1'b1, 1'b0, 32'h8400_000C, 3'b010, '0);
        repeat (4) drive(1'b0, 1'b0, 32'h8400_000C, 3'b000, '0);

        // Reset asserted mid-WENABLE aborts the write
        q.push_back(mk(1'b0, 1'b1, 1'b1, 3'b010, 32'h8400_0020, 32'h5A5A_A5A5));
        drive(1'b1, 1'b1, 32'h8400_0020, 3'b010, '0);
        drive(1'b0, 1'b1, 32'h8400_0020, 3'b000, 32'h5A5A_A5A5);
        drive(1'b0, 1'b1, 32'h8400_0020, 3'b000, '0);
        chk("pre_reset_penable", 64'(Penable), 64'd1);
        #1 Hreset = 1'b1;
        #1 chk_reset_outputs("mid_reset");
        valid = 1'b0; Hwrite = 1'b0;
        @(posedge Hclk); #1;
        Hreset = 1'b0;
        drive(1'b0, 1'b0, '0, 3'b000, '0);

        // First transfer after reset behaves from IDLE
        push_read(32'h8000_0030, 3'b001);
        drive(1'b1, 1'b0, 32'h8000_0030, 3'b001, '0);
        repeat (3) drive(1'b0, 1'b0, 32'h8000_0030, 3'b000, '0);

`ifdef APB_PREADY_WAIT_EN
        // Read with Pready low for three enable cycles
        q.push_back(mk(1'b0, 1'b0, 1'b0, 3'b001, 32'h8000_0040, '0));
        repeat (4) q.push_back(mk(1'b1, 1'b0, 1'b0, 3'b001, 32'h8000_0040, '0));
        drive(1'b1, 1'b0, 32'h8000_0040, 3'b001, '0);
        Pready = 1'b0;
        repeat (4) drive(1'b0, 1'b0, 32'h8000_0040, 3'b000, '0);
        Pready = 1'b1;
        repeat (3) drive(1'b0, 1'b0, 32'h8000_0040, 3'b000, '0);
`endif

        chk("queue_drained", 64'(q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
